// File: rtl/hs_counter_pkg.sv
// Shared types and limits for the 4-phase handshake counter chain.
// Stage states and the supported chain length live here.
package hs_counter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACK       = 2'd1,
        CARRY_REQ = 2'd2,
        CARRY_REL = 2'd3
    } stage_state_t;

    localparam int unsigned MAX_STAGES = 32;

endpackage

// File: rtl/hs_counter_stage.sv
// One counter bit with a 4-phase handshake on each side.
// A set bit passes the request on as a carry before clearing.
module hs_counter_stage
    import hs_counter_pkg::*;
#(
    parameter bit WRAP = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic lreq,
    output logic lack,
    output logic rreq,
    input  logic rack,
    output logic q,
    output logic busy
);

    stage_state_t st_q, st_d;
    logic         q_q, q_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= IDLE;
            q_q  <= 1'b0;
        end else begin
            st_q <= st_d;
            q_q  <= q_d;
        end
    end

    always_comb begin
        st_d = st_q;
        q_d  = q_q;
        unique case (st_q)
            IDLE: begin
                if (lreq) begin
                    if (!q_q) begin
                        q_d  = 1'b1;
                        st_d = ACK;
                    end else if (WRAP) begin
                        q_d  = 1'b0;
                        st_d = ACK;
                    end else begin
                        st_d = CARRY_REQ;
                    end
                end
            end
            CARRY_REQ: begin
                if (rack) st_d = CARRY_REL;
            end
            CARRY_REL: begin
                // bit clears only once the carry handshake has fully returned
                if (!rack) begin
                    q_d  = 1'b0;
                    st_d = ACK;
                end
            end
            ACK: begin
                if (!lreq) st_d = IDLE;
            end
        endcase
    end

    assign lack = (st_q == ACK);
    assign rreq = (st_q == CARRY_REQ);
    assign q    = q_q;
    assign busy = (st_q != IDLE);

endmodule

// File: rtl/hs_counter_chain.sv
// Ripple chain of handshake counter stages with an armed left input.
// The top stage either hands its carry out on ro/ao or wraps.
module hs_counter_chain
    import hs_counter_pkg::*;
#(
    parameter int STAGES    = 9,
    parameter bit CARRY_OUT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ri,
    output logic              ai,
    output logic              ro,
    input  logic              ao,
    output logic [STAGES-1:0] count,
    output logic              busy
);

    if (STAGES < 1 || STAGES > int'(MAX_STAGES)) begin : g_bad_stages
        $error("hs_counter_chain: STAGES out of range");
    end

    logic armed_q, armed_d;

    // a request level held across reset must not count
    assign armed_d = armed_q | ~ri;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) armed_q <= 1'b0;
        else     armed_q <= armed_d;
    end

    logic [STAGES-1:0] lreq_w;
    logic [STAGES-1:0] lack_w;
    logic [STAGES-1:0] rreq_w;
    logic [STAGES-1:0] rack_w;
    logic [STAGES-1:0] q_w;
    logic [STAGES-1:0] busy_w;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign lreq_w[k] = ri & armed_q;
        end else begin : g_mid
            assign lreq_w[k] = rreq_w[k-1];
        end

        if (k == STAGES - 1) begin : g_top
            assign rack_w[k] = ao;
        end else begin : g_inner
            assign rack_w[k] = lack_w[k+1];
        end

        hs_counter_stage #(
            .WRAP((k == STAGES - 1) && (CARRY_OUT == 1'b0))
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .lreq (lreq_w[k]),
            .lack (lack_w[k]),
            .rreq (rreq_w[k]),
            .rack (rack_w[k]),
            .q    (q_w[k]),
            .busy (busy_w[k])
        );
    end

    assign ai    = lack_w[0];
    assign ro    = CARRY_OUT ? rreq_w[STAGES-1] : 1'b0;
    assign count = q_w;
    assign busy  = |busy_w;

endmodule

// File: doc/hs_counter_chain.md
# hs_counter_chain

Parametrised, clocked synchronous model of a chain of 4-phase handshake counter stages. Every complete request/acknowledge cycle on the left port increments an internal STAGES-bit binary count. Carries ripple stage to stage over internal 4-phase handshakes. On overflow, the block either signals a carry handshake on the right port or wraps silently, depending on a parameter. It sits between a request source and an optional downstream carry consumer, and exposes the settled count for observation.

## Interface
- STAGES, 9: number of counter stages (count width); legal range 1..32.
- CARRY_OUT, 1: 1 = the top-stage carry performs a 4-phase handshake on ro/ao; 0 = the top stage wraps internally, ro tied 0, ao ignored.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ri  in  1  left request (4-phase).
- ai  out  1  left acknowledge.
- ro  out  1  right (carry) request; constant 0 when CARRY_OUT=0.
- ao  in  1  right (carry) acknowledge.
- count  out  STAGES  current count, LSB = stage 0; stable whenever busy=0.
- busy  out  1  1 while any stage is not in IDLE.

## Operation
- Each stage k holds a state (IDLE, ACK, CARRY_REQ, CARRY_REL) and a bit q[k].
- Stage k left side: stage 0 uses ri/ai; stage k>0 uses ro[k-1]/ai[k]. Right side: ro[k]/ai[k+1]. The top stage uses the external ro/ao.
- IDLE: ai=0, ro=0. On a sampled left request of 1:
  - q=0: set q:=1 and go to ACK.
  - q=1 and not a top stage with CARRY_OUT=0: go to CARRY_REQ.
  - q=1 and a top stage with CARRY_OUT=0: set q:=0 and go to ACK.
- CARRY_REQ: ro=1. On right ack = 1, go to CARRY_REL with ro=0.
- CARRY_REL: on right ack = 0, set q:=0 and go to ACK.
- ACK: ai=1. On left request = 0, go to IDLE with ai=0.
- All ai/ro are registered state outputs with no combinational path from input to output.
- Stage 0 input arming: after reset, stage 0 ignores ri until ri has been sampled 0 at least once. This armed flag is cleared by rst.
- count = q[STAGES-1:0]. It is modulo 2^STAGES over completed left handshakes.
- busy = OR of (state != IDLE) over all stages, plus (ri & armed & stage 0 IDLE) = 0. busy is purely the state OR.
- Protocol violations are not checked: ri falling before ai rises, or ao changing out of order. Behaviour under them is undefined but must not lock up after rst.

## Timing
- Reset values: ai=0, ro=0, count=0, busy=0, all states IDLE, armed=0. These are applied asynchronously on rst and hold while it is asserted.
- Reset mid-operation: all in-flight handshakes are abandoned. The environment must drop ri and ao.
- Left ack latency is measured from the first edge sampling ri=1 to ai=1. It is 1+4k cycles, where k = number of consecutive trailing ones in count, capped at STAGES-1 when CARRY_OUT=0.
- ai falls 1 cycle after ri is sampled 0.
- Overflow with CARRY_OUT=1: ro rises 1+(STAGES-1) edges after ri is sampled high. The handshake then extends by the external ao response time.
- count updates on the same edge as the q change. Intermediate ripple values are visible while busy=1.

## Structure
- Package hs_counter_pkg contains:
  - stage_state_t, a 2-bit enum: IDLE, ACK, CARRY_REQ, CARRY_REL.
  - Constant MAX_STAGES=32.
- Sub-module hs_counter_stage contains:
  - Parameter WRAP (1 only for the top stage with CARRY_OUT=0).
  - Ports: clk, rst, lreq, lack, rreq, rack, q, busy.
- The top level holds a generate loop of STAGES instances, the stage-0 armed flag, and the count/busy reduction.

## Test plan
- Reset (STAGES=4, CARRY_OUT=1):
  - Assert rst mid-cycle with ri=1 -> ai=0, ro=0, count=0, busy=0 immediately.
  - ri held at 1 after release -> no ai until ri is sampled 0 and then 1.
- Single count: from count=0, raise ri -> ai=1 exactly 1 cycle later, count=1. Drop ri -> ai=0 after 1 cycle, busy=0.
- Carry ripple: from count=3 (0011), raise ri -> ai rises after 9 cycles, count=4 (0100).
- Overflow, CARRY_OUT=1:
  - From count=15, raise ri -> ro=1 after 4 edges, ai still 0.
  - Respond with ao=1 and then ao=0 -> ai=1 follows, count=0.
- Overflow, CARRY_OUT=0: from count=15, raise ri -> ai rises after 13 cycles, count=0, ro stays 0.
- Soak (STAGES=9): run 600 random-delay handshakes -> count=600 mod 512 = 88. Exactly one ro handshake occurs. busy=0 at the end.
